// File: rtl/garage_motor_driver.sv
// Garage door H-bridge driver with dead-time on direction changes,
// PWM soft-start ramp to full duty and a latched overcurrent fault.
module garage_motor_driver #(
    parameter int PWM_BITS    = 8,
    parameter int RAMP_STEP   = 16,
    parameter int DEAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] control,
    input  logic       oc_fault,
    output logic       hb_up,
    output logic       hb_down,
    output logic       brake,
    output logic       at_speed,
    output logic       fault
);

    localparam int DCW = $clog2(DEAD_CYCLES + 1);
    localparam logic [PWM_BITS:0] FULL = {1'b1, {PWM_BITS{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAD,
        S_RAMP,
        S_RUN,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS:0]   duty_q, duty_d;
    logic [DCW-1:0]      dead_cnt_q, dead_cnt_d;
    logic                dir_q, dir_d;
    logic                hb_up_q, hb_up_d;
    logic                hb_down_q, hb_down_d;
    logic                brake_q, brake_d;
    logic                at_speed_q, at_speed_d;
    logic                fault_q, fault_d;

    logic                run_cmd;
    logic                cmd_dir;
    logic                wrap;
    logic                drive;
    logic [PWM_BITS+1:0] duty_sum;

    // dir encoding: 0 = up, 1 = down (matches control[0] when running)
    assign run_cmd  = control[1];
    assign cmd_dir  = control[0];
    assign wrap     = &pwm_cnt_q;
    assign duty_sum = {1'b0, duty_q} + (PWM_BITS + 2)'(RAMP_STEP);

    always_comb begin
        state_d    = state_q;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        duty_d     = duty_q;
        dead_cnt_d = dead_cnt_q;
        dir_d      = dir_q;

        unique case (state_q)
            S_IDLE: begin
                duty_d = '0;
                if (run_cmd) begin
                    dir_d      = cmd_dir;
                    dead_cnt_d = DCW'(DEAD_CYCLES);
                    state_d    = S_DEAD;
                end
            end
            S_DEAD: begin
                if (oc_fault) begin
                    duty_d  = '0;
                    state_d = S_FAULT;
                end else if (!run_cmd) begin
                    duty_d  = '0;
                    state_d = S_IDLE;
                end else if (cmd_dir != dir_q) begin
                    dir_d      = cmd_dir;
                    dead_cnt_d = DCW'(DEAD_CYCLES);
                end else if (dead_cnt_q <= DCW'(1)) begin
                    dead_cnt_d = '0;
                    duty_d     = '0;
                    state_d    = S_RAMP;
                end else begin
                    dead_cnt_d = dead_cnt_q - 1'b1;
                end
            end
            S_RAMP, S_RUN: begin
                if (oc_fault) begin
                    duty_d  = '0;
                    state_d = S_FAULT;
                end else if (!run_cmd) begin
                    duty_d  = '0;
                    state_d = S_IDLE;
                end else if (cmd_dir != dir_q) begin
                    dir_d      = cmd_dir;
                    dead_cnt_d = DCW'(DEAD_CYCLES);
                    duty_d     = '0;
                    state_d    = S_DEAD;
                end else if (state_q == S_RAMP && wrap) begin
                    // duty only moves at the period boundary: no glitches
                    if (duty_sum >= {1'b0, FULL}) begin
                        duty_d  = FULL;
                        state_d = S_RUN;
                    end else begin
                        duty_d = duty_sum[PWM_BITS:0];
                    end
                end
            end
            S_FAULT: begin
                duty_d = '0;
                if (!run_cmd && !oc_fault) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                duty_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        drive = (state_d == S_RUN) ||
                (state_d == S_RAMP && {1'b0, pwm_cnt_d} < duty_d);
        hb_up_d    = drive && !dir_d;
        hb_down_d  = drive && dir_d;
        brake_d    = (state_d == S_IDLE) || (state_d == S_DEAD);
        at_speed_d = (state_d == S_RUN);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            dead_cnt_q <= '0;
            dir_q      <= 1'b0;
            hb_up_q    <= 1'b0;
            hb_down_q  <= 1'b0;
            brake_q    <= 1'b1;
            at_speed_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            dead_cnt_q <= dead_cnt_d;
            dir_q      <= dir_d;
            hb_up_q    <= hb_up_d;
            hb_down_q  <= hb_down_d;
            brake_q    <= brake_d;
            at_speed_q <= at_speed_d;
            fault_q    <= fault_d;
        end
    end

    assign hb_up    = hb_up_q;
    assign hb_down  = hb_down_q;
    assign brake    = brake_q;
    assign at_speed = at_speed_q;
    assign fault    = fault_q;

endmodule

// File: doc/garage_motor_driver.md
Name: garage_motor_driver

Overview:
- Downstream stage of the garage door controller FSM. It consumes the 2-bit `control` command (00 stop, 10 open/up, 11 close/down) and drives the door motor H-bridge.
- Enforces dead-time on every direction change and a PWM soft-start ramp to full duty.
- Latches an overcurrent fault and holds the bridge off until the controller commands stop.

Parameters:
- PWM_BITS, 8, PWM counter width; PWM period = 2^PWM_BITS clk cycles.
- RAMP_STEP, 16, duty increment per PWM period during ramp; legal range 1..2^PWM_BITS.
- DEAD_CYCLES, 16, clk cycles with both bridge legs off before driving a new direction; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- control  in  2  command from door controller; 10 = up, 11 = down, 00 and 01 = stop.
- oc_fault  in  1  overcurrent flag, synchronous to clk, active-high.
- hb_up  out  1  PWM-gated enable for the up leg of the H-bridge.
- hb_down  out  1  PWM-gated enable for the down leg of the H-bridge.
- brake  out  1  low-side brake (both motor terminals shorted).
- at_speed  out  1  high while in RUN (full duty).
- fault  out  1  fault latched, high while in FAULT.

Behaviour:
- Reset values (async, applies immediately, including mid-operation):
  - state = IDLE, pwm_cnt = 0, duty = 0, dead_cnt = 0, dir = up.
  - Outputs: hb_up = 0, hb_down = 0, brake = 1, at_speed = 0, fault = 0.
- Output timing:
  - All outputs are flops loaded from next-state values, so they change on the same edge as the state.
  - A control change sampled at edge N is visible on outputs immediately after edge N.
- pwm_cnt: free-running, PWM_BITS wide, wraps from 2^PWM_BITS-1 to 0 in every state.
- duty: PWM_BITS+1 bits wide.
  - Leg-on condition: (pwm_cnt < duty) within the active direction.
  - duty = 2^PWM_BITS means 100% on.
- States:
  - IDLE: hb_up = hb_down = 0, brake = 1, duty = 0.
    - control = 10 or 11: latch dir, load dead_cnt = DEAD_CYCLES, go to DEAD.
  - DEAD: both legs 0, brake = 1. dead_cnt decrements each cycle.
    - DEAD lasts exactly DEAD_CYCLES cycles, then RAMP with duty = 0.
    - control -> stop: go to IDLE.
    - control -> opposite direction: update dir and reload dead_cnt (stay in DEAD).
  - RAMP: brake = 0; the leg for dir is driven by PWM, the other leg is 0.
    - At each pwm_cnt wrap (cnt == max), duty = min(duty + RAMP_STEP, 2^PWM_BITS).
    - duty changes only at wrap, so there are no mid-period glitches.
    - Enter RUN on the wrap where duty reaches 2^PWM_BITS.
  - RUN: active leg constantly 1, at_speed = 1.
  - RAMP/RUN on control change:
    - stop: IDLE next edge; legs 0, brake 1, duty cleared.
    - opposite direction: DEAD with new dir and dead_cnt = DEAD_CYCLES; legs 0 on that edge, duty cleared.
    - same direction: no effect.
  - FAULT: hb_up = hb_down = brake = 0 (coast), fault = 1, duty = 0.
    - Exits to IDLE only on a cycle where control is stop and oc_fault = 0.
- Fault entry:
  - oc_fault = 1 in DEAD, RAMP or RUN: FAULT next edge.
  - Fault has priority over any simultaneous control change.
  - oc_fault in IDLE is ignored.
- Invariants:
  - hb_up & hb_down is never 1.
  - Between the last cycle either leg is driven and the first cycle the opposite leg is driven, there are at least DEAD_CYCLES cycles with both legs 0.
  - No leg is driven while brake = 1.

Test Plan:
- Override parameters: PWM_BITS = 4, RAMP_STEP = 4, DEAD_CYCLES = 3.
- Reset, control = 00 -> hb_up = hb_down = 0, brake = 1, at_speed = fault = 0. Assert rst mid-RUN -> same values without waiting for a clock edge.
- control 00 -> 10 -> 3 cycles with both legs 0 and brake = 1. Then hb_up duty steps 0/16, 4/16, 8/16, 12/16, 16/16 per 16-cycle period. at_speed = 1 from the wrap where duty hits 16; hb_down stays 0 throughout.
- In RUN up, switch control to 11 -> hb_up = 0 the next edge, exactly 3 cycles of both legs 0, then hb_down ramps from duty 0. Check hb_up & hb_down never both 1.
- In DEAD (dir up), flip control to 11 after 2 cycles -> dead_cnt reloads, 3 further idle cycles, then down ramp. Flip to 00 instead -> IDLE, brake = 1.
- In RAMP, pulse oc_fault for 1 cycle together with control = 11 -> FAULT: legs 0, brake 0, fault = 1. Keep control = 10 -> stays in FAULT. Set control = 00 -> IDLE, fault = 0.
- control = 01 from IDLE -> no motion. control 10 -> 01 during RUN -> IDLE on the next edge.
